// File: rtl/pixel_binarize_bbox.sv
// Binarises a raster grey-pixel stream (dark = 1), tracks x/y coordinates and
// accumulates the bounding box of dark pixels over one frame.
//
// state  | meaning
// S_IDLE | waiting for start after reset
// S_RUN  | consuming pixels, busy=1
// S_DONE | frame complete, bbox/found published until next start
module pixel_binarize_bbox #(
  parameter int data_width = 8,
  parameter int img_width  = 160,
  parameter int img_height = 120,
  parameter int x_width    = 8,
  parameter int y_width    = 7,
  parameter int threshold  = 128
) (
  input  logic                  clka,
  input  logic                  rsta_n,
  input  logic                  start,
  input  logic [data_width-1:0] pix_in,
  input  logic                  pix_valid,
  output logic                  bin_out,
  output logic                  bin_valid,
  output logic [x_width-1:0]    x_out,
  output logic [y_width-1:0]    y_out,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic [x_width-1:0]    bbox_xmin,
  output logic [x_width-1:0]    bbox_xmax,
  output logic [y_width-1:0]    bbox_ymin,
  output logic [y_width-1:0]    bbox_ymax
);

  localparam logic [x_width-1:0]    x_last = x_width'(img_width - 1);
  localparam logic [y_width-1:0]    y_last = y_width'(img_height - 1);
  localparam logic [data_width-1:0] thr    = data_width'(threshold);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state;
  logic [x_width-1:0] x_cnt, xmin_r, xmax_r, n_xmin, n_xmax;
  logic [y_width-1:0] y_cnt, ymin_r, ymax_r, n_ymin, n_ymax;
  logic               found_r, n_found, dark, last;

  // Next bounding box if the current pixel is accepted.
  always_comb begin
    dark    = (pix_in < thr);
    last    = (x_cnt == x_last) && (y_cnt == y_last);
    n_found = found_r;
    n_xmin  = xmin_r;
    n_xmax  = xmax_r;
    n_ymin  = ymin_r;
    n_ymax  = ymax_r;
    if (dark) begin
      n_found = 1'b1;
      if (!found_r) begin
        n_xmin = x_cnt;
        n_xmax = x_cnt;
        n_ymin = y_cnt;
        n_ymax = y_cnt;
      end else begin
        if (x_cnt < xmin_r) n_xmin = x_cnt;
        if (x_cnt > xmax_r) n_xmax = x_cnt;
        if (y_cnt < ymin_r) n_ymin = y_cnt;
        if (y_cnt > ymax_r) n_ymax = y_cnt;
      end
    end
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state     <= S_IDLE;
      x_cnt     <= '0;
      y_cnt     <= '0;
      found_r   <= 1'b0;
      xmin_r    <= '0;
      xmax_r    <= '0;
      ymin_r    <= '0;
      ymax_r    <= '0;
      bin_out   <= 1'b0;
      bin_valid <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      found     <= 1'b0;
      bbox_xmin <= '0;
      bbox_xmax <= '0;
      bbox_ymin <= '0;
      bbox_ymax <= '0;
    end else begin
      bin_valid <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_RUN;
            busy      <= 1'b1;
            done      <= 1'b0;
            found     <= 1'b0;
            bbox_xmin <= '0;
            bbox_xmax <= '0;
            bbox_ymin <= '0;
            bbox_ymax <= '0;
            x_cnt     <= '0;
            y_cnt     <= '0;
            found_r   <= 1'b0;
            xmin_r    <= '0;
            xmax_r    <= '0;
            ymin_r    <= '0;
            ymax_r    <= '0;
          end
        end
        S_RUN: begin
          if (pix_valid) begin
            bin_valid <= 1'b1;
            bin_out   <= dark;
            x_out     <= x_cnt;
            y_out     <= y_cnt;
            found_r   <= n_found;
            xmin_r    <= n_xmin;
            xmax_r    <= n_xmax;
            ymin_r    <= n_ymin;
            ymax_r    <= n_ymax;
            if (last) begin
              state     <= S_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              found     <= n_found;
              bbox_xmin <= n_found ? n_xmin : '0;
              bbox_xmax <= n_found ? n_xmax : '0;
              bbox_ymin <= n_found ? n_ymin : '0;
              bbox_ymax <= n_found ? n_ymax : '0;
            end else if (x_cnt == x_last) begin
              x_cnt <= '0;
              y_cnt <= y_cnt + 1'b1;
            end else begin
              x_cnt <= x_cnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
